// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: IR field positions, branch encodings, FSM states.
package fetch_pkg;

  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 26;
  localparam int RS_HI   = 25;
  localparam int RS_LO   = 22;
  localparam int RT_HI   = 21;
  localparam int RT_LO   = 18;
  localparam int RD_HI   = 17;
  localparam int RD_LO   = 14;
  localparam int FUNC_HI = 3;
  localparam int FUNC_LO = 0;
  localparam int IMM_HI  = 17;
  localparam int IMM_LO  = 0;
  localparam int BOFF_HI = 25;
  localparam int BOFF_LO = 0;

  // Codes 6 and 7 are reserved and resolve to not-taken.
  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_ALW  = 3'd1,
    BR_Z    = 3'd2,
    BR_NZ   = 3'd3,
    BR_N    = 3'd4,
    BR_P    = 3'd5
  } br_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] boff_sext(input logic [31:0] ir);
    return {{(31 - BOFF_HI){ir[BOFF_HI]}}, ir[BOFF_HI:BOFF_LO]};
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch condition evaluation from br_op and the ALU flags.
module branch_resolve
  import fetch_pkg::*;
(
  input  logic [2:0] br_op,
  input  logic       flag_z,
  input  logic       flag_n,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (br_op)
      BR_ALW:  taken = 1'b1;
      BR_Z:    taken = flag_z;
      BR_NZ:   taken = ~flag_z;
      BR_N:    taken = flag_n;
      BR_P:    taken = ~flag_n;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, IR, req/valid memory fetch FSM and branch PC update.
// Optional pc bounds check compiled in with `define FETCH_BOUNDS_CHK_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          AW         = 10,
  parameter int unsigned RESET_PC   = 0,
  parameter int unsigned IMEM_DEPTH = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_req,
  input  logic          inc_pc,
  input  logic [2:0]    br_op,
  input  logic          flag_z,
  input  logic          flag_n,
  input  logic          halt,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          imem_valid,
  output logic          ir_valid,
  output logic          busy,
  output logic [AW-1:0] pc,
  output logic [5:0]    opcode,
  output logic [3:0]    rs,
  output logic [3:0]    rt,
  output logic [3:0]    rd,
  output logic [3:0]    func,
  output logic [17:0]   imm,
  output logic          fault
);

  fetch_state_t  state_reg;
  logic [AW-1:0] pc_reg;
  logic [AW-1:0] pc_next;
  logic [AW-1:0] boff;
  logic [31:0]   ir_reg;
  logic          ir_valid_reg;
  logic          imem_req_reg;
  logic [AW-1:0] imem_addr_reg;
  logic          taken;
  logic          bounds_err;
  logic          fault_blk;
  logic          start_fetch;

  branch_resolve u_branch_resolve (
    .br_op  (br_op),
    .flag_z (flag_z),
    .flag_n (flag_n),
    .taken  (taken)
  );

  // Offset is sign-extended then truncated, so branch targets wrap modulo 2^AW.
  assign boff = AW'(boff_sext(ir_reg));

  always_comb begin
    pc_next = pc_reg;
    if (inc_pc) begin
      if (taken) pc_next = pc_reg + AW'(1) + boff;
      else       pc_next = pc_reg + AW'(1);
    end
  end

`ifdef FETCH_BOUNDS_CHK_EN
  logic fault_reg;

  assign bounds_err = (32'(pc_next) >= 32'(IMEM_DEPTH));
  assign fault_blk  = fault_reg;
  assign fault      = fault_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_reg <= 1'b0;
    end else if (state_reg == ST_IDLE && fetch_req && !halt && bounds_err) begin
      fault_reg <= 1'b1;
    end
  end
`else
  assign bounds_err = 1'b0;
  assign fault_blk  = 1'b0;
  assign fault      = 1'b0;

  // IMEM_DEPTH only matters to the bounds check; addresses simply alias here.
  if (IMEM_DEPTH == 0) begin : g_zero_depth
  end
`endif

  // The fetch address comes from pc_next so a same-cycle inc_pc is honoured.
  assign start_fetch = (state_reg == ST_IDLE) && fetch_req && !halt && !fault_blk && !bounds_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      pc_reg        <= AW'(RESET_PC);
      ir_reg        <= '0;
      ir_valid_reg  <= 1'b0;
      imem_req_reg  <= 1'b0;
      imem_addr_reg <= '0;
    end else begin
      pc_reg       <= pc_next;
      imem_req_reg <= 1'b0;
      if (inc_pc) ir_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start_fetch) begin
            state_reg     <= ST_REQ;
            imem_req_reg  <= 1'b1;
            imem_addr_reg <= pc_next;
          end
        end
        ST_REQ: state_reg <= ST_WAIT;
        ST_WAIT: begin
          if (imem_valid) begin
            ir_reg       <= imem_rdata;
            ir_valid_reg <= 1'b1;
            state_reg    <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign imem_req  = imem_req_reg;
  assign imem_addr = imem_addr_reg;
  assign ir_valid  = ir_valid_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign pc        = pc_reg;
  assign opcode    = ir_reg[OPC_HI:OPC_LO];
  assign rs        = ir_reg[RS_HI:RS_LO];
  assign rt        = ir_reg[RT_HI:RT_LO];
  assign rd        = ir_reg[RD_HI:RD_LO];
  assign func      = ir_reg[FUNC_HI:FUNC_LO];
  assign imm       = ir_reg[IMM_HI:IMM_LO];

endmodule
